// File: rtl/bubble_buffer_loader_pkg.sv
// bubble_pkg: shared codes, region positions, byte counts and FSM states for bubble_buffer_loader.
// BUBBLE_LOADER_4BIT_EN selects four channels per position instead of two.
package bubble_pkg;
    typedef enum logic [2:0] {ACC_BOOT = 3'b110, ACC_USER = 3'b111} acc_e;
    typedef enum logic [2:0] {S_IDLE, S_FILL, S_FETCH, S_SHIFT, S_FIN} state_e;
    localparam logic [23:0] BOOT_BASE = 24'h000000;
    localparam logic [23:0] PAGE_BASE = 24'h000200;
    localparam logic [12:0] BOOT_START = 13'd0;
    localparam logic [12:0] BOOT_SYNC_LO = 13'd1987;
    localparam logic [12:0] BOOT_SYNC_HI = 13'd2050;
    localparam logic [12:0] BOOT_DATA = 13'd2053;
    localparam logic [12:0] BOOT_TAIL_END = 13'd4105;
    localparam logic [12:0] BOOT_PAD = 13'd8190;
    localparam logic [12:0] BOOT_END = 13'd8191;
    localparam logic [12:0] USER_START = 13'd7168;
    localparam logic [12:0] USER_DATA = 13'd7171;
    localparam logic [12:0] USER_END = 13'd7751;
    localparam logic [8:0] BOOT_BYTES = 9'd480;
    localparam logic [8:0] USER_BYTES = 9'd128;
`ifdef BUBBLE_LOADER_4BIT_EN
    localparam logic [1:0] CH_LAST = 2'd3;
`else
    localparam logic [1:0] CH_LAST = 2'd1;
`endif
endpackage

// File: rtl/bubble_buffer_loader_if.sv
// bubble_buffer_loader_if: load request, byte source handshake and buffer write port.
interface bubble_buffer_loader_if;
    logic        LOAD_REQ;
    logic [2:0]  ACCTYPE;
    logic [11:0] ABSPOS;
    logic        SRC_RD;
    logic [23:0] SRC_ADDR;
    logic        SRC_VALID;
    logic [7:0]  SRC_DATA;
    logic [14:0] BUFWADDR;
    logic        BUFWCLK;
    logic        BUFWDATA;
    logic        BUSY;
    logic        DONE;
    modport master (
        input  LOAD_REQ, ACCTYPE, ABSPOS, SRC_VALID, SRC_DATA,
        output SRC_RD, SRC_ADDR, BUFWADDR, BUFWCLK, BUFWDATA, BUSY, DONE
    );
    modport slave (
        output LOAD_REQ, ACCTYPE, ABSPOS, SRC_VALID, SRC_DATA,
        input  SRC_RD, SRC_ADDR, BUFWADDR, BUFWCLK, BUFWDATA, BUSY, DONE
    );
endinterface

// File: rtl/bubble_buffer_loader_serializer.sv
// bubble_bit_serializer: shifts a captured byte out LSB first and flags its eighth bit.
module bubble_bit_serializer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       advance,
    input  logic [7:0] din,
    output logic       data_bit,
    output logic       last_bit
);
    logic [7:0] sh;
    logic [2:0] cnt;
    always_ff @(posedge clk)
        if (rst) begin
            sh <= '0;
            cnt <= '0;
        end else if (load) begin
            sh <= din;
            cnt <= '0;
        end else if (advance) begin
            sh <= {1'b0, sh[7:1]};
            cnt <= cnt + 3'd1;
        end
    assign data_bit = sh[0];
    assign last_bit = cnt == 3'd7;
endmodule

// File: rtl/bubble_buffer_loader.sv
// bubble_buffer_loader: builds the BOOT or USER page bit image and writes it into the bubble buffer.
// BUBBLE_LOADER_4BIT_EN widens the channel field to two bits (four channels per position).
module bubble_buffer_loader
    import bubble_pkg::*;
(
    input  logic MCLK,
    input  logic RST,
    bubble_buffer_loader_if.master bus
);
    state_e      state, state_nxt;
    logic [12:0] pos, pos_adv;
    logic [1:0]  ch, ch_adv;
    logic [23:0] src_addr;
    logic [8:0]  bytes_left;
    logic        is_boot, ph, last_ch, last_slot, req_ok, fill_bit, ser_bit, ser_last;
    bubble_bit_serializer u_ser (
        .clk(MCLK),
        .rst(RST),
        .load(state == S_FETCH && bus.SRC_VALID),
        .advance(state == S_SHIFT && ph),
        .din(bus.SRC_DATA),
        .data_bit(ser_bit),
        .last_bit(ser_last)
    );
    // ph doubles as the write strobe: phase A = 0, phase B = 1
    always_ff @(posedge MCLK)
        if (RST) begin
            state <= S_IDLE;
            ph <= 1'b0;
            pos <= '0;
            ch <= '0;
            src_addr <= '0;
            bytes_left <= '0;
            is_boot <= 1'b0;
        end else begin
            state <= state_nxt;
            ph <= (state == S_FILL || state == S_SHIFT) && !ph;
            if (state == S_IDLE && req_ok) begin
                is_boot <= bus.ACCTYPE == ACC_BOOT;
                pos <= bus.ACCTYPE == ACC_BOOT ? BOOT_START : USER_START;
                ch <= '0;
                src_addr <= bus.ACCTYPE == ACC_BOOT ? BOOT_BASE : PAGE_BASE + {5'd0, bus.ABSPOS, 7'd0};
                bytes_left <= bus.ACCTYPE == ACC_BOOT ? BOOT_BYTES : USER_BYTES;
            end
            if (ph && !last_slot) begin
                pos <= pos_adv;
                ch <= ch_adv;
            end
            if (state == S_SHIFT && ph && ser_last) begin
                bytes_left <= bytes_left - 9'd1;
                src_addr <= src_addr + 24'd1;
            end
        end
    always_comb begin
        last_ch = ch == CH_LAST;
        ch_adv = last_ch ? 2'd0 : ch + 2'd1;
        pos_adv = !last_ch ? pos : (is_boot && pos == BOOT_TAIL_END) ? BOOT_PAD : pos + 13'd1;
        last_slot = last_ch && pos == (is_boot ? BOOT_END : USER_END);
        req_ok = bus.LOAD_REQ && (bus.ACCTYPE == ACC_BOOT || bus.ACCTYPE == ACC_USER);
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = req_ok ? S_FILL : S_IDLE;
            S_FILL:  if (ph) state_nxt = last_slot ? S_FIN :
                         (ch_adv == 2'd0 && pos_adv == (is_boot ? BOOT_DATA : USER_DATA)) ? S_FETCH : S_FILL;
            S_FETCH: state_nxt = bus.SRC_VALID ? S_SHIFT : S_FETCH;
            S_SHIFT: if (ph && ser_last) state_nxt = bytes_left == 9'd1 ? S_FILL : S_FETCH;
            default: state_nxt = S_IDLE;
        endcase
    end
    // positions after the data bytes (4-bit mode) reuse the region's trailing filler
    always_comb begin
        fill_bit = is_boot && pos < BOOT_PAD && !(ch == 2'd0 && pos >= BOOT_SYNC_LO && pos <= BOOT_SYNC_HI);
`ifdef BUBBLE_LOADER_4BIT_EN
        bus.BUFWADDR = {pos, ch};
`else
        bus.BUFWADDR = {1'b0, pos, ch[0]};
`endif
        bus.BUFWCLK = ph;
        bus.BUFWDATA = state == S_SHIFT ? ser_bit : state == S_FILL && fill_bit;
        bus.SRC_RD = state == S_FETCH;
        bus.SRC_ADDR = src_addr;
        bus.BUSY = state != S_IDLE;
        bus.DONE = state == S_FIN;
    end
endmodule

// File: doc/bubble_buffer_loader.md
# bubble_buffer_loader

Upstream fill stage for the bubble output buffer: on a load request it builds the bit image of the bootloader or a user page and writes it bit by bit through the buffer write port (BUFWADDR/BUFWCLK/BUFWDATA). Data bytes come from a byte-wide source, such as a flash reader, over a request/valid handshake. Filler, sync and padding patterns are generated internally. The block runs entirely in the 48 MHz MCLK domain, and BUFWCLK is a registered strobe derived from MCLK.

## Interface
- BOOT_BASE, 24'h000000, source byte address of bootloader byte 0
- PAGE_BASE, 24'h000200, source byte address of page 0 byte 0
- MCLK  in  1  48 MHz clock
- RST  in  1  synchronous, active-high reset
- LOAD_REQ  in  1  one-cycle load request
- ACCTYPE  in  3  access type, sampled with LOAD_REQ: 3'b110 = BOOT, 3'b111 = USER
- ABSPOS  in  12  page number, sampled with LOAD_REQ
- SRC_RD  out  1  byte read request
- SRC_ADDR  out  24  byte address, stable while SRC_RD is high
- SRC_VALID  in  1  byte valid, one cycle
- SRC_DATA  in  8  byte data, valid with SRC_VALID
- BUFWADDR  out  15  buffer bit address
- BUFWCLK  out  1  write strobe; its rising edge writes
- BUFWDATA  out  1  write bit
- BUSY  out  1  load in progress
- DONE  out  1  one-cycle pulse at load completion

## Operation
- Address mapping
  - 2-bit mode: BUFWADDR = {pos, ch}, where pos is a 13-bit position and ch is the channel (0 = D0, 1 = D1).
  - Writes go ch0 then ch1 for each position, in ascending pos order.
- States
  - IDLE → FILL | FETCH | SHIFT → FIN → IDLE.
  - FILL emits constant patterns.
  - FETCH holds SRC_RD and waits for SRC_VALID.
  - SHIFT emits 8 bits of the captured byte, LSB first.
  - FIN pulses DONE.
- BOOT sequence, as pos: (ch0, ch1)
  - 0–1986: (1,1)
  - 1987–2050: (0,1)
  - 2051: (1,1)
  - 2052: (1,1)
  - 2053–3972: 3840 data bits from bytes 0..479 at BOOT_BASE+i
  - 3973–4105: (1,1)
  - 8190–8191: (0,0)
  - Total: 8216 writes.
- USER sequence
  - 7168–7170: (0,0)
  - 7171–7682: 1024 data bits from bytes PAGE_BASE + (ABSPOS<<7) + i, i = 0..127
  - 7683–7751: (0,0)
  - Total: 1168 writes.
- Data bit k of a region lands at {start_pos, 1'b0} + k, so even bits go to D0.
- Source address arithmetic is 24-bit unsigned. Overflow wraps modulo 2^24.
- LOAD_REQ handling
  - Accepted only in IDLE.
  - Ignored while BUSY.
  - Ignored if ACCTYPE is neither BOOT nor USER; no BUSY and no DONE follow.
- Source handshake
  - SRC_RD rises with SRC_ADDR stable and holds until SRC_VALID.
  - SRC_DATA is captured in the SRC_VALID cycle, and SRC_RD is low the next cycle.
  - SRC_VALID while SRC_RD is low is ignored.
  - No timeout: the FSM waits indefinitely.
- Reset
  - All outputs are 0: BUFWADDR = 0, BUFWCLK = 0, BUFWDATA = 0, SRC_RD = 0, SRC_ADDR = 0, BUSY = 0, DONE = 0.
  - RST mid-load aborts to IDLE on the next edge and drops BUFWCLK and SRC_RD.
  - Buffer contents after an aborted load are undefined.

## Timing
- Each bit write takes 2 MCLK cycles.
  - Phase A: BUFWADDR and BUFWDATA update, BUFWCLK = 0.
  - Phase B: BUFWCLK = 1, address and data held.
  - This gives one full cycle of setup before the strobe rises.
- LOAD_REQ at edge N → BUSY = 1 at N+1, and the first phase A is also at N+1.
- Byte fetch
  - SRC_RD rises in the cycle after the previous byte's last phase B.
  - Phase A of the byte's bit 0 is the cycle after SRC_VALID.
- DONE is high for exactly one cycle after the final phase B, with BUSY still 1. BUSY falls the next cycle.
- A BOOT load with zero-latency SRC_VALID (valid in the first SRC_RD cycle) takes 8216×2 + 480×1 + 1 cycles.

## Configuration
- BUBBLE_LOADER_4BIT_EN defined:
  - BUFWADDR = {pos, ch[1:0]}.
  - Each position writes 4 channels, ch0..ch3.
  - Filler positions write the same value on ch2 and ch3 as on ch1.
  - Data bit k lands at {start_pos, 2'b00} + k.
- Undefined: 2-bit mode as above, BUFWADDR[14] = 0.

## Structure
- Package bubble_pkg holds:
  - ACCTYPE codes BOOT and USER
  - region start/end positions
  - byte counts 480 and 128
  - the state enum
- Sub-module bubble_bit_serializer: 8-bit shift register plus 3-bit counter, with load and advance inputs and last_bit and bit outputs.
- Top level holds the FSM, position/channel counters and the source address generator.

## Test plan
- Reset: RST held 3 cycles → all outputs 0. Then LOAD_REQ with ACCTYPE=3'b101 → BUSY stays 0 and DONE never pulses.
- BOOT load with source byte i = i[7:0], zero latency → exactly 8216 BUFWCLK rises, then the checks below.
  - Addresses 3974/3975 (pos 1987) = 0/1.
  - Address 4106 (pos 2053, ch0) = bit0 of byte 0 = 0.
  - Address 4108 (pos 2054, ch0) = bit2 of byte 0 = 0.
  - Address 4115 (pos 2057, ch1) = bit1 of byte 1 = 0.
  - Address 4114 (pos 2057, ch0) = bit0 of byte 1 = 1.
- USER load, ABSPOS = 12'd5 → SRC_ADDR sequence 24'h000480 .. 24'h0004FF, 1168 writes, first write at address 14336 with data 0, DONE pulse once.
- SRC_VALID delayed 7 cycles per byte → SRC_ADDR and SRC_RD stable throughout the wait, no BUFWCLK rise during the wait, final image identical to the zero-latency run.
- LOAD_REQ pulsed mid-load → ignored, with a single DONE at the end. RST asserted at write 500 → IDLE on the next edge, BUFWCLK = 0, then a new BOOT load completes normally.
- BUBBLE_LOADER_4BIT_EN defined, USER load → first data write at address 28684 (7171×4), 2336 writes.
